// File: rtl/gamepad_poll_ctrl.sv
// gamepad_poll_ctrl: latches and serially polls two gamepads, publishing decoded button states per frame
module gamepad_poll_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int PAD_BITS = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                poll_now,
  input  logic [15:0]         poll_period,
  output logic                pad_latch,
  output logic                pad_clk,
  input  logic                pad1_data,
  input  logic                pad2_data,
  output logic [PAD_BITS-1:0] pad1_state,
  output logic [PAD_BITS-1:0] pad2_state,
  output logic [1:0]          pad_present,
  output logic                frame_valid,
  output logic                state_changed,
  output logic                busy
);
  localparam int BCW = $clog2(PAD_BITS + 1);
  typedef enum logic [2:0] {IDLE, LATCH, GAP, CLK_LO, CLK_HI, DONE, WAIT} state_t;
  state_t state, state_n;
  logic [7:0] pre;
  logic [BCW-1:0] bit_cnt;
  logic [15:0] wait_cnt, period_q;
  logic [1:0] sync1, sync2;
  logic [PAD_BITS-1:0] shift1, shift2;
  logic pending, tick, last_bit, wait_done;
  assign tick      = pre == 8'(CLK_DIV - 1);
  assign last_bit  = bit_cnt == BCW'(PAD_BITS - 1);
  assign wait_done = period_q == 16'd0 || (tick && wait_cnt + 16'd1 == period_q);
  assign busy      = state != IDLE && state != WAIT;
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // Next-state logic: every timed phase advances on a prescaler tick, DONE lasts one system cycle
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (enable || poll_now || pending) ? LATCH : IDLE;
      LATCH:   state_n = tick ? GAP : LATCH;
      GAP:     state_n = tick ? CLK_LO : GAP;
      CLK_LO:  state_n = tick ? CLK_HI : CLK_LO;
      CLK_HI:  state_n = !tick ? CLK_HI : last_bit ? DONE : CLK_LO;
      DONE:    state_n = WAIT;
      WAIT:    state_n = wait_done ? IDLE : WAIT;
      default: state_n = IDLE;
    endcase
  end
  // Prescaler, bit/wait counters, request merging and pad data capture
  // The prescaler is held at zero in IDLE so each frame starts on a fresh tick, and in DONE so
  // that the inter-frame wait spans exactly poll_period full ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre      <= '0;
      bit_cnt  <= '0;
      wait_cnt <= '0;
      period_q <= '0;
      pending  <= 1'b0;
      sync1    <= '0;
      sync2    <= '0;
      shift1   <= '0;
      shift2   <= '0;
    end else begin
      pre      <= (state == IDLE || state == DONE || tick) ? '0 : pre + 8'd1;
      bit_cnt  <= state == GAP ? '0 : (state == CLK_HI && tick && !last_bit) ? bit_cnt + BCW'(1) : bit_cnt;
      wait_cnt <= state != WAIT ? '0 : tick ? wait_cnt + 16'd1 : wait_cnt;
      period_q <= state == DONE ? poll_period : period_q;
      pending  <= state == IDLE ? 1'b0 : pending || poll_now;
      sync1    <= {sync1[0], pad1_data};
      sync2    <= {sync2[0], pad2_data};
      if (state == CLK_LO && tick) begin
        shift1 <= {shift1[PAD_BITS-2:0], sync1[1]};
        shift2 <= {shift2[PAD_BITS-2:0], sync2[1]};
      end
    end
  end
  // Registered pad strobes and frame results, loaded as the FSM enters DONE so they align with frame_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_latch     <= 1'b0;
      pad_clk       <= 1'b0;
      frame_valid   <= 1'b0;
      state_changed <= 1'b0;
      pad1_state    <= '0;
      pad2_state    <= '0;
      pad_present   <= '0;
    end else begin
      pad_latch     <= state_n == LATCH;
      pad_clk       <= state_n == CLK_HI;
      frame_valid   <= state_n == DONE;
      state_changed <= state_n == DONE && (~shift1 != pad1_state || ~shift2 != pad2_state);
      if (state_n == DONE) begin
        pad1_state  <= ~shift1;
        pad2_state  <= ~shift2;
        pad_present <= {|shift2, |shift1};
      end
    end
  end
endmodule

// File: tb/tb_gamepad_poll_ctrl.sv
// tb_gamepad_poll_ctrl: scoreboard bench with serial pad models and a frame-level reference model
module tb_gamepad_poll_ctrl;
  localparam int P = 12;
  localparam int D = 4;
  localparam int FRAME = (2 + 2 * P) * D + 1;
  logic clk = 0, rst_n = 0, enable = 0, poll_now = 0;
  logic [15:0] poll_period = 0;
  logic pad_latch, pad_clk, pad1_data, pad2_data, frame_valid, state_changed, busy;
  logic [P-1:0] pad1_state, pad2_state;
  logic [1:0] pad_present;
  typedef struct {
    logic [P-1:0] s1;
    logic [P-1:0] s2;
    logic [1:0]   pres;
    logic         chg;
    int           t;
  } exp_t;
  exp_t q[$];
  exp_t me;
  int nc = 0, nm = 0, cyc = 0, latch_rises = 0, lat_cyc = 0, pulses = 0, idx = -1, k = 0, base = 0;
  logic [P-1:0] raw1 = '1, raw2 = '1, prev1 = '0, prev2 = '0;
  logic tie2 = 0, pclk_d = 0, pl_m = 0, pc_m = 0;

  gamepad_poll_ctrl #(.CLK_DIV(D), .PAD_BITS(P)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .poll_now(poll_now), .poll_period(poll_period),
    .pad_latch(pad_latch), .pad_clk(pad_clk), .pad1_data(pad1_data), .pad2_data(pad2_data),
    .pad1_state(pad1_state), .pad2_state(pad2_state), .pad_present(pad_present),
    .frame_valid(frame_valid), .state_changed(state_changed), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pad model: latch reloads the shift position, each pad_clk rise presents the next bit, MSB first
  always @(posedge clk) begin
    if (pad_latch) idx <= P - 1;
    else if (pad_clk && !pclk_d) idx <= idx - 1;
    pclk_d <= pad_clk;
  end
  assign pad1_data = idx >= 0 ? raw1[idx[3:0]] : 1'b1;
  assign pad2_data = tie2 ? 1'b0 : idx >= 0 ? raw2[idx[3:0]] : 1'b1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nc++;
    if (a !== e) begin
      nm++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic push(input int t);
    exp_t e;
    logic [P-1:0] r2;
    r2 = tie2 ? '0 : raw2;
    e.s1 = ~raw1;
    e.s2 = ~r2;
    e.pres = {r2 != 0, raw1 != 0};
    e.chg = e.s1 != prev1 || e.s2 != prev2;
    e.t = t;
    prev1 = e.s1;
    prev2 = e.s2;
    q.push_back(e);
  endtask

  function automatic int gap(input int p);
    return (p == 0 ? 1 : p * D) + 1 + FRAME;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_poll();
    poll_now = 1;
    step(1);
    poll_now = 0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q.size() != 0) begin
      nc++;
      nm++;
      $display("FAIL drain: %0d frames outstanding after %0d cycles", q.size(), budget);
      q.delete();
    end
  endtask

  task automatic one_frame();
    k = cyc;
    push(k + FRAME);
    pulse_poll();
    drain(300);
    step(5);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          lat_cyc = 0;
          pulses = 0;
          pl_m = 0;
          pc_m = 0;
        end else begin
          if (pad_latch) lat_cyc++;
          if (pad_latch && !pl_m) latch_rises++;
          if (pad_clk && !pc_m) pulses++;
          pl_m = pad_latch;
          pc_m = pad_clk;
          if (frame_valid) begin
            if (q.size() == 0) begin
              nc++;
              nm++;
              $display("FAIL unexpected_frame: frame_valid at cycle %0d with no frame expected", cyc);
            end else begin
              me = q.pop_front();
              chk("frame_cycle", 32'(cyc), 32'(me.t));
              chk("pad1_state", 32'(pad1_state), 32'(me.s1));
              chk("pad2_state", 32'(pad2_state), 32'(me.s2));
              chk("pad_present", 32'(pad_present), 32'(me.pres));
              chk("state_changed", 32'(state_changed), 32'(me.chg));
              chk("latch_cycles", 32'(lat_cyc), 32'(D));
              chk("clk_pulses", 32'(pulses), 32'(P));
              chk("busy_in_done", 32'(busy), 32'd1);
            end
            lat_cyc = 0;
            pulses = 0;
          end else if (state_changed) begin
            nc++;
            nm++;
            $display("FAIL stray_changed: state_changed=1 without frame_valid at cycle %0d", cyc);
          end
        end
      end
    join_none
    #2;
    chk("reset_outputs", 32'({pad_latch, pad_clk, frame_valid, state_changed, busy, pad_present}), 32'd0);
    chk("reset_states", 32'({pad1_state, pad2_state}), 32'd0);
    step(2);
    rst_n = 1;
    step(2);
    raw1 = 12'hFFE;
    raw2 = 12'hFFF;
    one_frame();
    one_frame();
    tie2 = 1;
    one_frame();
    tie2 = 0;
    poll_period = 3;
    base = latch_rises;
    k = cyc;
    push(k + FRAME);
    push(k + FRAME + gap(3));
    push(k + FRAME + 2 * gap(3));
    enable = 1;
    step(2 * gap(3) + 50);
    enable = 0;
    drain(400);
    step(200);
    chk("latch_after_disable", 32'(latch_rises - base), 32'd3);
    poll_period = 0;
    raw1 = 12'h5A5;
    base = latch_rises;
    k = cyc;
    push(k + FRAME);
    pulse_poll();
    step(29);
    pulse_poll();
    step(19);
    pulse_poll();
    push(k + FRAME + gap(0));
    drain(400);
    step(200);
    chk("pending_frames", 32'(latch_rises - base), 32'd2);
    raw1 = 12'h3C3;
    raw2 = 12'hF0F;
    k = cyc;
    push(k + FRAME);
    pulse_poll();
    step(53);
    chk("pad_clk_before_abort", 32'(pad_clk), 32'd1);
    rst_n = 0;
    #1;
    chk("abort_outputs", 32'({pad_latch, pad_clk, frame_valid, state_changed, busy, pad_present}), 32'd0);
    chk("abort_states", 32'({pad1_state, pad2_state}), 32'd0);
    q.delete();
    prev1 = '0;
    prev2 = '0;
    step(3);
    rst_n = 1;
    step(2);
    one_frame();
    for (int i = 0; i < 8; i++) begin
      raw1 = 12'($urandom);
      raw2 = 12'($urandom);
      tie2 = $urandom_range(0, 3) == 0;
      poll_period = 16'($urandom_range(0, 4));
      k = cyc;
      push(k + FRAME);
      pulse_poll();
      drain(300);
      step(4 * int'(poll_period) + 6);
    end
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nm);
    $finish;
  end
endmodule
